fp_mul_norm_round: RTL and testbench
====================================

// Module: fp_mul_norm_round
// PURPOSE
//   Post-multiply normalise/round stage for the FP32 multiplier datapath.
//   - Consumes the raw 48-bit significand product, provisional exponent, sign and operand class.
//   - Produces a packed IEEE-754 single result plus exception flags.
//   - 2-stage pipeline with valid/ready backpressure, sitting directly downstream of the multiplier core.
// PARAMETERS
//   EXP_W   10   width of signed provisional exponent in_exp (two's complement)
//   BIAS    127  FP32 exponent bias; used only for range checks
// PORTS
//   CLK         in   1      clock, rising edge
//   RST         in   1      asynchronous, active-low reset
//   in_valid    in   1      input beat valid
//   in_ready    out  1      stage can accept a beat this cycle
//   in_sign     in   1      result sign (signA ^ signB)
//   in_exp      in   EXP_W  biased exponent sum eA+eB-BIAS, signed
//   in_mant     in   48     {1,mA}*{1,mB}; bit47 or bit46 is the leading one
//   in_cls      in   2      operand class: 0 normal, 1 zero, 2 inf, 3 nan
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts result
//   out_result  out  32     packed FP32 result
//   out_flags   out  4      {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//   Reset: s1_valid, s2_valid, out_valid = 0; out_result = 0; out_flags = 0. Reset mid-flight drops all beats.
//   Handshake:
//     - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational).
//     - Beat accepted when in_valid & in_ready; result held stable while out_valid & !out_ready.
//   Latency: exactly 2 cycles with out_ready held 1; throughput 1 beat/cycle. Order is preserved.
//   S1 (normalise):
//     - in_mant[47]=1: frac = mant[46:24], G = mant[23], S = |mant[22:0], e = in_exp+1.
//     - in_mant[47]=0: frac = mant[45:23], G = mant[22], S = |mant[21:0], e = in_exp.
//     - in_cls, in_sign pass through unchanged.
//   S2 (round/pack), evaluated in this priority order:
//     1. cls=nan -> 0x7FC00000, invalid = 1.
//     2. cls=inf -> {sign, 8'hFF, 23'h0}.
//     3. cls=zero -> {sign, 31'h0}.
//     4. Round frac; a carry out of the 24-bit significand forces frac = 0 and e = e+1.
//     5. e >= 255 -> {sign, 8'hFF, 0}, overflow = 1, inexact = 1.
//     6. e <= 0 -> {sign, 31'h0}, underflow = 1, inexact = 1. No subnormals; flush to zero.
//     7. Otherwise {sign, e[7:0], frac}, inexact = G|S.
//   Arithmetic: e is carried at EXP_W+1 bits signed, so no wrap; in_exp range is -127..383.
//   out_flags is per-beat, not sticky, and is valid only with out_valid.
// CONFIGURATION
//   FP_MUL_RNE_EN defined: round-to-nearest-even; increment when G & (S | frac[0]).
//   FP_MUL_RNE_EN undefined: truncate; never increment. inexact still reports G|S.
// STRUCTURE
//   - Package fp_mul_pkg: class enum (CLS_NORMAL/ZERO/INF/NAN), FP32_QNAN = 32'h7FC00000,
//     FP32_BIAS, EXP_MAX = 255, flag bit indices (FLG_INV/OVF/UNF/INX).
//   - Sub-module fp_round_inc: combinational {frac, G, S} -> {carry, rounded frac}; holds the FP_MUL_RNE_EN ifdef.
//   - Pipeline registers and handshake stay in this module.
// TESTING
//   1. 1.5*1.5: in_exp = 127, in_mant = 48'h9000_0000_0000, cls = 0 -> 0x40100000, flags 0, 2 cycles later.
//   2. Tie: in_exp = 127, in_mant = 48'h4000_00C0_0000 -> RNE_EN: 0x3F800002, inexact = 1;
//      without the macro: 0x3F800001, inexact = 1.
//   3. Round carry: in_exp = 127, in_mant = 48'h7FFF_FFC0_0000 -> RNE_EN: 0x40000000 (exponent bump).
//   4. Overflow/underflow:
//      - in_exp = 254, in_mant[47] = 1 -> 0x7F800000 with ovf + inx.
//      - in_exp = 0, in_mant = 48'h4000_0000_0000 -> 0x00000000 with unf + inx.
//   5. Specials: cls = 3 -> 0x7FC00000 inv; cls = 2 with sign = 1 -> 0xFF800000; cls = 1 with sign = 1 -> 0x80000000.
//   6. Backpressure/reset:
//      - Hold out_ready = 0 and push 3 beats -> in_ready drops after 2 accepted; release -> all 3 out in order, no loss.
//      - Assert RST with 2 beats in flight -> out_valid = 0 next cycle, no stale result afterwards.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier post-normalise stage.
// Operand classes, special encodings and flag bit positions.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_e;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam int FP32_BIAS = 127;
  localparam int EXP_MAX   = 255;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef struct packed {
    logic        sign;
    cls_e        cls;
    logic [22:0] frac;
    logic        g;
    logic        s;
  } norm_t;

endpackage

// File: rtl/fp_mul_norm_round_inc.sv
// Significand rounding increment for the FP32 multiplier.
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise truncate.
module fp_round_inc (
  input  logic [22:0] frac,
  input  logic        g,
  input  logic        s,
  output logic        carry,
  output logic [22:0] frac_out
);

`ifdef FP_MUL_RNE_EN
  logic inc;

  assign inc = g & (s | frac[0]);
  assign {carry, frac_out} = {1'b0, frac} + 24'(inc);
`else
  logic unused_gs;

  assign unused_gs = g ^ s;
  assign carry     = 1'b0;
  assign frac_out  = frac;
`endif

endmodule

// File: rtl/fp_mul_norm_round.sv
// FP32 multiply normalise/round/pack, 2-stage valid/ready pipeline.
// Rounding mode set by FP_MUL_RNE_EN (see fp_round_inc).
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int BIAS  = FP32_BIAS
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [47:0]             in_mant,
  input  logic [1:0]              in_cls,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic [3:0]              out_flags
);

  localparam int EW = EXP_W + 1;
  localparam int EMAX =
    (BIAS == FP32_BIAS) ? EXP_MAX : 2 * BIAS + 1;
  localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);

  logic adv1, adv2;
  logic s1_valid, s2_valid;

  norm_t                 n1, s1;
  logic signed [EW-1:0]  n1_exp, s1_exp;

  logic                  carry;
  logic [22:0]           r_frac;
  logic signed [EW-1:0]  r_exp;
  logic [31:0]           res;
  logic [3:0]            flg;

  assign adv2      = !s2_valid | out_ready;
  assign adv1      = !s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // normalise: pick leading-one position, split frac/guard/sticky
  always_comb begin
    n1      = '0;
    n1.sign = in_sign;
    n1.cls  = cls_e'(in_cls);
    n1_exp  = {in_exp[EXP_W-1], in_exp};
    if (in_mant[47]) begin
      n1.frac = in_mant[46:24];
      n1.g    = in_mant[23];
      n1.s    = |in_mant[22:0];
      n1_exp  = {in_exp[EXP_W-1], in_exp} + EW'(1);
    end else begin
      n1.frac = in_mant[45:23];
      n1.g    = in_mant[22];
      n1.s    = |in_mant[21:0];
    end
  end

  // stage 1 register: normalised beat
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s1_exp   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1     <= n1;
        s1_exp <= n1_exp;
      end
    end
  end

  fp_round_inc u_round (
    .frac     (s1.frac),
    .g        (s1.g),
    .s        (s1.s),
    .carry    (carry),
    .frac_out (r_frac)
  );

  assign r_exp = s1_exp + EW'(carry);

  // round/pack with specials first, then range checks
  always_comb begin
    res = {s1.sign, r_exp[7:0], r_frac};
    flg = '0;
    unique case (s1.cls)
      CLS_NAN: begin
        res          = FP32_QNAN;
        flg[FLG_INV] = 1'b1;
      end
      CLS_INF:  res = {s1.sign, 8'hFF, 23'h0};
      CLS_ZERO: res = {s1.sign, 31'h0};
      CLS_NORMAL: begin
        if (r_exp >= EMAX_E) begin
          res          = {s1.sign, 8'hFF, 23'h0};
          flg[FLG_OVF] = 1'b1;
          flg[FLG_INX] = 1'b1;
        end else if (r_exp[EW-1] || r_exp == '0) begin
          res          = {s1.sign, 31'h0};
          flg[FLG_UNF] = 1'b1;
          flg[FLG_INX] = 1'b1;
        end else begin
          flg[FLG_INX] = s1.g | s1.s;
        end
      end
      default: res = FP32_QNAN;
    endcase
  end

  // stage 2 register: packed result held under backpressure
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_flags  <= flg;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Bench for fp_mul_norm_round: integer rounding model plus scoreboard,
// directed vectors with literal expectations, backpressure and reset.
module tb_fp_mul_norm_round;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic signed [9:0] in_exp = '0;
  logic [47:0]       in_mant = '0;
  logic [1:0]        in_cls = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_result;
  logic [3:0]        out_flags;

  int checks = 0;
  int errors = 0;
  bit rnd_rdy = 1'b0;

  typedef struct {
    bit          sg;
    int          ex;
    logic [47:0] m;
    logic [1:0]  cls;
    logic [35:0] lit;
  } vec_t;

  vec_t        vt[12];
  logic [35:0] expq[$];

  always #5 CLK = ~CLK;

  fp_mul_norm_round dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_cls     (in_cls),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  function automatic logic [35:0] model(
    bit sg, int ex, logic [47:0] m, logic [1:0] cls);
    longint unsigned mm, keep, rem, half;
    int  sh, e;
    bit  inx, up;
    logic [7:0] e8;
    if (cls == 2'd3) return {4'b1000, 32'h7FC0_0000};
    if (cls == 2'd2) return {4'b0000, sg, 8'hFF, 23'h0};
    if (cls == 2'd1) return {4'b0000, sg, 31'h0};
    mm   = 64'(m);
    sh   = m[47] ? 24 : 23;
    e    = m[47] ? ex + 1 : ex;
    keep = mm >> sh;
    rem  = mm & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    up   = 1'b0;
`ifdef FP_MUL_RNE_EN
    up = (rem > half) || (rem == half && keep[0]);
`endif
    keep = keep + 64'(up);
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {4'b0101, sg, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, sg, 31'h0};
    e8 = e[7:0];
    return {3'b000, inx, sg, e8, keep[22:0]};
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // scoreboard: record accepted beats, compare every delivered result
  always @(negedge CLK) begin
    logic [35:0] e;
    if (RST && in_valid && in_ready)
      expq.push_back(model(in_sign, int'(in_exp), in_mant, in_cls));
    if (RST && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_out actual=%h required=none",
                 {out_flags, out_result});
      end else begin
        e = expq.pop_front();
        chk("result", {28'h0, out_flags, out_result}, {28'h0, e});
      end
    end
  end

  task automatic send(vec_t v);
    bit ok = 1'b0;
    in_sign  = v.sg;
    in_exp   = v.ex[9:0];
    in_mant  = v.m;
    in_cls   = v.cls;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      if (ok) break;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      if (expq.size() == 0 && !out_valid) break;
    end
    chk("drain", 64'(expq.size()), 0);
  endtask

  initial begin
    vec_t r;
    vt[0]  = '{0, 127, 48'h9000_0000_0000, 0, 36'h0_4010_0000};
`ifdef FP_MUL_RNE_EN
    vt[1]  = '{0, 127, 48'h4000_00C0_0000, 0, 36'h1_3F80_0002};
    vt[2]  = '{0, 127, 48'h7FFF_FFC0_0000, 0, 36'h1_4000_0000};
    vt[11] = '{0, 100, 48'h4000_0060_0000, 0, 36'h1_3200_0001};
`else
    vt[1]  = '{0, 127, 48'h4000_00C0_0000, 0, 36'h1_3F80_0001};
    vt[2]  = '{0, 127, 48'h7FFF_FFC0_0000, 0, 36'h1_3FFF_FFFF};
    vt[11] = '{0, 100, 48'h4000_0060_0000, 0, 36'h1_3200_0000};
`endif
    vt[3]  = '{0, 254, 48'h8000_0000_0000, 0, 36'h5_7F80_0000};
    vt[4]  = '{0, 0,   48'h4000_0000_0000, 0, 36'h3_0000_0000};
    vt[5]  = '{0, 5,   48'h4000_0000_0000, 3, 36'h8_7FC0_0000};
    vt[6]  = '{1, 5,   48'h4000_0000_0000, 2, 36'h0_FF80_0000};
    vt[7]  = '{1, 5,   48'h4000_0000_0000, 1, 36'h0_8000_0000};
    vt[8]  = '{1, 130, 48'hC000_0000_0001, 0, 36'h1_C1C0_0000};
    vt[9]  = '{0, -127, 48'h8000_0000_0000, 0, 36'h3_0000_0000};
    vt[10] = '{0, 383, 48'h8000_0000_0000, 0, 36'h5_7F80_0000};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_result", 64'(out_result), 0);
    chk("rst_out_flags", 64'(out_flags), 0);
    RST = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 1);

    foreach (vt[i])
      chk($sformatf("model_v%0d", i),
          64'(model(vt[i].sg, vt[i].ex, vt[i].m, vt[i].cls)),
          64'(vt[i].lit));

    send(vt[0]);
    @(negedge CLK);
    chk("latency_c1", 64'(out_valid), 0);
    @(negedge CLK);
    chk("latency_c2", 64'(out_valid), 1);
    drain();

    foreach (vt[i]) send(vt[i]);
    drain();

    out_ready = 1'b0;
    send(vt[1]);
    send(vt[5]);
    in_sign  = vt[8].sg;
    in_exp   = vt[8].ex[9:0];
    in_mant  = vt[8].m;
    in_cls   = vt[8].cls;
    in_valid = 1'b1;
    @(negedge CLK);
    chk("bp_in_ready", 64'(in_ready), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("bp_hold_ready", 64'(in_ready), 0);
    chk("bp_hold_valid", 64'(out_valid), 1);
    chk("bp_hold_result", 64'(out_result), 64'h3F80_0001 +
        64'(vt[1].lit[31:0] - 32'h3F80_0001));
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    send(vt[8]);
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r.sg  = 1'($urandom_range(0, 1));
      r.ex  = int'($urandom_range(0, 510)) - 127;
      r.m   = {16'($urandom), 32'($urandom)};
      if (!r.m[47]) r.m[46] = 1'b1;
      r.cls = ($urandom_range(0, 7) > 3) ? 2'd0 :
              2'($urandom_range(0, 3));
      r.lit = '0;
      send(r);
    end
    drain();
    rnd_rdy   = 1'b0;
    out_ready = 1'b0;

    send(vt[0]);
    send(vt[3]);
    RST = 1'b0;
    #1;
    chk("rst_flight_valid", 64'(out_valid), 0);
    expq.delete();
    @(negedge CLK);
    chk("rst_flight_result", 64'(out_result), 0);
    repeat (2) @(posedge CLK);
    #1;
    RST       = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge CLK);
    chk("rst_no_stale", 64'(out_valid), 0);
    @(posedge CLK);
    #1;
    send(vt[7]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
